// File: rtl/circular_buffer_reader.sv
// Read side of the 16-entry circular buffer: tracks occupancy against the writer's ticks,
// walks the read pointer and drives a one-entry registered valid/ready output stage.
module circular_buffer_reader #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_tick,
  input  logic          flush,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] data_out,
  output logic          valid,
  input  logic          ready,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          overflow
);

  typedef enum logic {StIdle = 1'b0, StHold = 1'b1} state_e;

  localparam logic [AW:0]   FullLevel = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LevelOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [DW-1:0] data_q, data_d;
  logic          overflow_q, overflow_d;
  logic          pop, load, full;

  assign pop  = (state_q == StHold) && ready;
  // A flush edge never loads; the output stage is discarded instead.
  assign load = !flush && (level_q != '0) && ((state_q == StIdle) || pop);
  assign full = (level_q == FullLevel);

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    data_d     = data_q;
    overflow_d = overflow_q;
    if (flush) begin
      // Jump to the writer's position; a same-edge tick becomes the only entry.
      rd_ptr_d   = rd_ptr_q + level_q[AW-1:0];
      level_d    = wr_tick ? LevelOne : '0;
      state_d    = StIdle;
      overflow_d = 1'b0;
    end else begin
      if (load) begin
        data_d   = rd_data;
        rd_ptr_d = rd_ptr_q + PtrOne;
        state_d  = StHold;
      end else if (pop) begin
        state_d = StIdle;
      end

      if (wr_tick && !load) begin
        if (full) begin
          // Writer overwrote the oldest unread entry: skip past it.
          rd_ptr_d   = rd_ptr_q + PtrOne;
          overflow_d = 1'b1;
        end else begin
          level_d = level_q + LevelOne;
        end
      end else if (load && !wr_tick) begin
        level_d = level_q - LevelOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_addr  = rd_ptr_q;
  assign data_out = data_q;
  assign valid    = (state_q == StHold);
  assign level    = level_q;
  assign empty    = (level_q == '0) && (state_q == StIdle);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_circular_buffer_reader.sv
// Bench for circular_buffer_reader: a modulo-counter writer plus buffer array, a queue-based
// model of the read stream checked every cycle, and directed literal checks per scenario.
module tb_circular_buffer_reader;

  logic       clk;
  logic       rst;
  logic       wr_tick;
  logic       flush;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic [4:0] level;
  logic       empty;
  logic       overflow;
  logic [7:0] wdata;

  logic [7:0] mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: entries written but not yet loaded, output stage, sticky flag, writer pointer.
  logic [7:0] q[$];
  logic       mv;
  logic [7:0] md;
  logic       md_ok;
  logic       mov;
  logic [3:0] wp;
  logic       do_wr;
  logic [3:0] wr_addr;
  logic [7:0] wr_val;

  circular_buffer_reader #(
    .DEPTH(16),
    .AW   (4),
    .DW   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_tick (wr_tick),
    .flush   (flush),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .data_out(data_out),
    .valid   (valid),
    .ready   (ready),
    .level   (level),
    .empty   (empty),
    .overflow(overflow)
  );

  assign rd_data = mem[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic pop;
    logic load;
    do_wr = 1'b0;
    if (rst) begin
      q.delete();
      mv    = 1'b0;
      md    = 8'h00;
      md_ok = 1'b1;
      mov   = 1'b0;
      wp    = 4'd0;
    end else begin
      do_wr   = wr_tick;
      wr_addr = wp;
      wr_val  = wdata;
      if (flush) begin
        q.delete();
        mv    = 1'b0;
        md_ok = 1'b0;
        mov   = 1'b0;
        if (wr_tick) q.push_back(wdata);
      end else begin
        pop  = mv && ready;
        load = (q.size() > 0) && (!mv || pop);
        if (load) begin
          md    = q.pop_front();
          mv    = 1'b1;
          md_ok = 1'b1;
        end else if (pop) begin
          mv = 1'b0;
        end
        if (wr_tick) begin
          q.push_back(wdata);
          if (q.size() > 16) begin
            void'(q.pop_front());
            mov = 1'b1;
          end
        end
      end
      if (wr_tick) wp = wp + 4'd1;
    end
  endtask

  // Per-cycle compare against the model, 1 time unit after each rising edge.
  initial begin
    logic [3:0] ea;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (do_wr) mem[wr_addr] = wr_val;
      ea = wp - 4'(q.size());
      check("m_level", 32'(level), 32'(q.size()));
      check("m_valid", 32'(valid), 32'(mv));
      check("m_empty", 32'(empty), 32'((q.size() == 0) && !mv));
      check("m_overflow", 32'(overflow), 32'(mov));
      check("m_rd_addr", 32'(rd_addr), 32'(ea));
      if (mv || md_ok) check("m_data_out", 32'(data_out), 32'(md));
    end
  end

  task automatic cyc(input logic t, input logic [7:0] d, input logic r, input logic f,
                     input logic rs);
    wr_tick = t;
    wdata   = d;
    ready   = r;
    flush   = f;
    rst     = rs;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst     = 1'b1;
    wr_tick = 1'b0;
    flush   = 1'b0;
    ready   = 1'b0;
    wdata   = 8'h00;
    @(negedge clk);
    cyc(0, 8'h00, 0, 0, 1);
    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_data", 32'(data_out), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_overflow", 32'(overflow), 0);

    // Three ticks streamed out with ready high.
    cyc(1, 8'h11, 1, 0, 0);
    check("t1_valid_e0", 32'(valid), 0);
    check("t1_level_e0", 32'(level), 1);
    cyc(1, 8'h22, 1, 0, 0);
    check("t1_valid_e1", 32'(valid), 1);
    check("t1_data0", 32'(data_out), 32'h11);
    cyc(1, 8'h33, 1, 0, 0);
    check("t1_data1", 32'(data_out), 32'h22);
    cyc(0, 8'h00, 1, 0, 0);
    check("t1_data2", 32'(data_out), 32'h33);
    cyc(0, 8'h00, 1, 0, 0);
    check("t1_empty", 32'(empty), 1);
    check("t1_overflow", 32'(overflow), 0);

    // Fill with ready low, then overflow.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
    check("t2_level15", 32'(level), 15);
    check("t2_valid", 32'(valid), 1);
    check("t2_data", 32'(data_out), 32'h40);
    check("t2_rd_addr", 32'(rd_addr), 4);
    cyc(1, 8'h50, 0, 0, 0);
    check("t2_level16", 32'(level), 16);
    check("t2_no_ovf", 32'(overflow), 0);
    cyc(1, 8'h51, 0, 0, 0);
    check("t2_ovf", 32'(overflow), 1);
    check("t2_rd_adv", 32'(rd_addr), 5);
    check("t2_level_sat", 32'(level), 16);
    for (int i = 0; i < 18; i++) cyc(0, 8'h00, 1, 0, 0);
    check("t2_drained", 32'(empty), 1);
    check("t2_ovf_sticky", 32'(overflow), 1);

    // Wrap-around with ready held high.
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'(i), 1, 0, 0);
      if (i >= 1) begin
        check("t3_data", 32'(data_out), 32'(i - 1));
        check("t3_rd_addr", 32'(rd_addr), 32'(i % 16));
      end
    end
    cyc(0, 8'h00, 1, 0, 0);
    check("t3_last", 32'(data_out), 19);
    cyc(0, 8'h00, 1, 0, 0);
    check("t3_empty", 32'(empty), 1);

    // Stall pattern: ready toggles.
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h80 + i), 1'(i % 2), 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 8'h00, 1'(i % 2), 0, 0);
    check("t4_empty", 32'(empty), 1);

    // Flush at level 5 with valid set and a same-edge tick.
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 18; i++) cyc(1, 8'(8'hC0 + i), 0, 0, 0);
    check("t5_ovf_set", 32'(overflow), 1);
    for (int i = 0; i < 11; i++) cyc(0, 8'h00, 1, 0, 0);
    check("t5_level5", 32'(level), 5);
    check("t5_rd13", 32'(rd_addr), 13);
    cyc(1, 8'hAB, 0, 1, 0);
    check("t5_valid0", 32'(valid), 0);
    check("t5_level1", 32'(level), 1);
    check("t5_ovf0", 32'(overflow), 0);
    check("t5_rd_jump", 32'(rd_addr), 2);
    cyc(0, 8'h00, 1, 0, 0);
    check("t5_valid1", 32'(valid), 1);
    check("t5_data_ab", 32'(data_out), 32'hAB);
    cyc(0, 8'h00, 1, 0, 0);
    check("t5_empty", 32'(empty), 1);

    // Reset mid-stream at level 7.
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
    check("t6_level7", 32'(level), 7);
    cyc(0, 8'h00, 0, 0, 1);
    check("t6_level", 32'(level), 0);
    check("t6_valid", 32'(valid), 0);
    check("t6_data", 32'(data_out), 0);
    check("t6_rd_addr", 32'(rd_addr), 0);
    check("t6_empty", 32'(empty), 1);
    cyc(1, 8'h5A, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    check("t6_restart_data", 32'(data_out), 32'h5A);
    check("t6_restart_rd", 32'(rd_addr), 1);
    cyc(0, 8'h00, 1, 0, 0);
    check("t6_final_empty", 32'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
